// File: rtl/tdm_mux8_pkg.sv
// Shared constants and types for the 8:1 TDM merging multiplexer.
package tdm_mux8_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/tdm_mux8_if.sv
// Bundle of the eight input lanes and the merged output channel of tdm_mux8.
// Handshake: a beat moves on any channel in a cycle where valid and ready are
// both high at the rising edge; valid/data stay stable until that edge, and
// valid never depends on ready.
interface tdm_mux8_if #(
  parameter int DW = 8
) ();

  logic                                 en;
  logic [tdm_mux8_pkg::NUM_LANES-1:0]    in_valid;
  logic [tdm_mux8_pkg::NUM_LANES*DW-1:0] in_data;
  logic [tdm_mux8_pkg::NUM_LANES-1:0]    in_ready;
  logic                                 out_valid;
  logic [DW-1:0]                        out_data;
  logic [tdm_mux8_pkg::SEL_W-1:0]        out_sel;
  logic                                 out_ready;

  // Environment side: drives the lanes and consumes the merged channel.
  modport master (
    output en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Multiplexer side.
  modport slave (
    input  en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/tdm_mux8_rr_arbiter8.sv
// Combinational 8-way arbiter. Scans from ptr upward with wrap-around; with
// TDM_MUX8_FIXED_PRIO_EN defined the scan always starts at lane 0.
module rr_arbiter8
  import tdm_mux8_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  sel_t                 ptr,
  output logic [NUM_LANES-1:0] gnt,
  output sel_t                 gnt_idx,
  output logic                 gnt_found
);

  sel_t start;

`ifdef TDM_MUX8_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = '0;
`else
  assign start = ptr;
`endif

  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      sel_t idx;
      // 3-bit add wraps naturally from lane 7 back to lane 0
      idx = start + sel_t'(k);
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  assign gnt = gnt_found ? (NUM_LANES'(1) << gnt_idx) : '0;

endmodule

// File: rtl/tdm_mux8.sv
// Eight-lane to one-lane merging multiplexer: grants one valid lane per load
// and registers its data with the lane index. Build option:
// TDM_MUX8_FIXED_PRIO_EN selects fixed priority (lane 0 highest) over round-robin.
module tdm_mux8
  import tdm_mux8_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic       clk,
  input  logic       rst,
  tdm_mux8_if.slave  bus
);

  logic [NUM_LANES-1:0] gnt;
  sel_t                 gnt_idx;
  logic                 gnt_found;
  logic                 load;
  logic                 out_valid_q;
  logic [DW-1:0]        out_data_q;
  sel_t                 out_sel_q;
  sel_t                 ptr;

  // Reset gates load so no lane sees an accept in the reset cycle.
  assign load = !rst && bus.en && (!out_valid_q || bus.out_ready);

  rr_arbiter8 u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_found (gnt_found)
  );

  assign bus.in_ready  = (load && gnt_found) ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      if (gnt_found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[gnt_idx*DW +: DW];
        out_sel_q   <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (bus.out_ready) begin
      // en low: the held beat still drains
      out_valid_q <= 1'b0;
    end
  end

`ifdef TDM_MUX8_FIXED_PRIO_EN
  assign ptr = '0;
`else
  sel_t ptr_q;
  assign ptr = ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (load && gnt_found) begin
      ptr_q <= gnt_idx + sel_t'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tdm_mux8.sv
// Directed self-checking bench for tdm_mux8 (default round-robin or
// TDM_MUX8_FIXED_PRIO_EN build).
module tb_tdm_mux8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  tdm_mux8_if #(.DW(8)) bus ();

  tdm_mux8 #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] d);
    bus.in_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.out_data); end
    checks++; if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", bus.out_sel); end
    checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL reset_ready got %h want 00", bus.in_ready); end
  endtask

  task automatic test_single_lane();
    step();
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    set_lane(5, 8'hA5);
    bus.in_valid = 8'h20;
    #1;
    checks++; if (bus.in_ready !== 8'h20) begin errors++; $display("FAIL single_ready got %h want 20", bus.in_ready); end
    step();
    bus.in_valid = 8'h00;
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_sel !== 3'd5) begin errors++; $display("FAIL single_sel got %0d want 5", bus.out_sel); end
    checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", bus.out_data); end
    checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL single_ready_drop got %h want 00", bus.in_ready); end
    step();
    // nothing valid at this load: the output empties
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sel;
    logic [7:0] exp_rdy;
    do_reset();
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) set_lane(i, 8'(i));
    bus.in_valid = 8'hFF;
    for (int c = 0; c < 10; c++) begin
`ifdef TDM_MUX8_FIXED_PRIO_EN
      exp_sel = 3'd0;
`else
      exp_sel = 3'(c % 8);
`endif
      exp_rdy = 8'h01 << exp_sel;
      #1;
      checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready cycle %0d got %h want %h", c, bus.in_ready, exp_rdy); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel || bus.out_data !== 8'(exp_sel)) begin
        errors++; $display("FAIL rr_beat cycle %0d got v=%0b sel=%0d data=%h want v=1 sel=%0d data=%h",
                           c, bus.out_valid, bus.out_sel, bus.out_data, exp_sel, 8'(exp_sel));
      end
    end
    bus.in_valid = 8'h00;
  endtask

  task automatic test_back_pressure();
    do_reset();
    bus.en = 1'b1;
    bus.out_ready = 1'b0;
    set_lane(0, 8'h11);
    bus.in_valid = 8'h01;
    step();
    set_lane(2, 8'h22);
    set_lane(6, 8'h66);
    bus.in_valid = 8'h44;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL bp_ready cycle %0d got %h want 00", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd0 || bus.out_data !== 8'h11) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%0b sel=%0d data=%h want v=1 sel=0 data=11",
                           c, bus.out_valid, bus.out_sel, bus.out_data);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 8'h04) begin errors++; $display("FAIL bp_refill_ready got %h want 04", bus.in_ready); end
    step();
    bus.in_valid = 8'h40;
    checks++; if (bus.out_sel !== 3'd2 || bus.out_data !== 8'h22) begin errors++; $display("FAIL bp_refill2 got sel=%0d data=%h want sel=2 data=22", bus.out_sel, bus.out_data); end
    #1;
    checks++; if (bus.in_ready !== 8'h40) begin errors++; $display("FAIL bp_refill6_ready got %h want 40", bus.in_ready); end
    step();
    bus.in_valid = 8'h00;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd6 || bus.out_data !== 8'h66) begin
      errors++; $display("FAIL bp_refill6 got v=%0b sel=%0d data=%h want v=1 sel=6 data=66", bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_enable();
    do_reset();
    bus.en = 1'b1;
    bus.out_ready = 1'b0;
    set_lane(0, 8'h5A);
    bus.in_valid = 8'h01;
    step();
    bus.en = 1'b0;
    set_lane(3, 8'h3C);
    bus.in_valid = 8'h08;
    #1;
    checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL en_ready_held got %h want 00", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin errors++; $display("FAIL en_hold got v=%0b data=%h want v=1 data=5a", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL en_ready_drain got %h want 00", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL en_drain got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL en_ready_idle got %h want 00", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL en_idle got %0b want 0", bus.out_valid); end
    bus.en = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 8'h08) begin errors++; $display("FAIL en_grant_ready got %h want 08", bus.in_ready); end
    step();
    bus.in_valid = 8'h00;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 3'd3 || bus.out_data !== 8'h3C) begin
      errors++; $display("FAIL en_grant got v=%0b sel=%0d data=%h want v=1 sel=3 data=3c", bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_reset_mid();
    // beat from lane 3 is held; ptr sits at 4 in the round-robin build
    bus.out_ready = 1'b0;
    set_lane(1, 8'h77);
    set_lane(5, 8'h99);
    bus.in_valid = 8'h22;
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 8'h00) begin errors++; $display("FAIL rstmid_ready got %h want 00", bus.in_ready); end
    step();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 3'd0 || bus.out_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_out got v=%0b sel=%0d data=%h want v=0 sel=0 data=00", bus.out_valid, bus.out_sel, bus.out_data);
    end
    bus.out_ready = 1'b1;
    #1;
    // pointer back at lane 0: lane 1 wins over lane 5
    checks++; if (bus.in_ready !== 8'h02) begin errors++; $display("FAIL rstmid_ptr_ready got %h want 02", bus.in_ready); end
    step();
    bus.in_valid = 8'h20;
    checks++; if (bus.out_sel !== 3'd1 || bus.out_data !== 8'h77) begin errors++; $display("FAIL rstmid_grant got sel=%0d data=%h want sel=1 data=77", bus.out_sel, bus.out_data); end
    step();
    bus.in_valid = 8'h00;
    checks++; if (bus.out_sel !== 3'd5 || bus.out_data !== 8'h99) begin errors++; $display("FAIL rstmid_next got sel=%0d data=%h want sel=5 data=99", bus.out_sel, bus.out_data); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_back_pressure();
    test_enable();
    test_reset_mid();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
